// File: rtl/serial_frame_rx.sv
// serial_frame_rx: asynchronous serial byte receiver with mid-bit sampling,
// framing/overrun detection and a valid/ready output handshake.
module serial_frame_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    input  logic              ready,
    output logic              frame_err,
    output logic              overrun
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT} state_t;
    state_t state, state_nx;

    logic [2:0]        sync;
    logic [TW-1:0]     tmr;
    logic [BW-1:0]     bit_idx;
    logic [DATA_W-1:0] sr;
    logic              din_s, fall, tick, done, bad;

    // sync[1] is the metastability-filtered line, sync[2] its previous value
    assign din_s = sync[1];
    assign fall  = sync[2] & ~sync[1];
    assign tick  = tmr == '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        bad      = 1'b0;
        case (state)
            IDLE:    state_nx = fall ? START : IDLE;
            START:   state_nx = !tick ? START : din_s ? IDLE : DATA;
            DATA:    state_nx = (tick && bit_idx == LAST) ? STOP : DATA;
            STOP: begin
                state_nx = !tick ? STOP : din_s ? IDLE : WAIT;
                done     = tick & din_s;
                bad      = tick & ~din_s;
            end
            WAIT:    state_nx = din_s ? IDLE : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync      <= '1;
            tmr       <= '0;
            bit_idx   <= '0;
            sr        <= '0;
            dout      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync      <= {sync[1:0], din};
            tmr       <= (state == IDLE && fall) ? HALF : tick ? FULL : tmr - TW'(1);
            bit_idx   <= (state == START) ? '0 : (state == DATA && tick) ? bit_idx + BW'(1) : bit_idx;
            sr        <= (state == DATA && tick) ? {din_s, sr[DATA_W-1:1]} : sr;
            frame_err <= bad;
            overrun   <= done & valid & ~ready;
            // a word arriving in the same cycle as a consume reloads and keeps valid high
            if (done && (!valid || ready)) begin
                dout  <= sr;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: drives framed serial bytes and checks received words,
// flag pulses and their cycle timing against an event-level model.
module tb_serial_frame_rx;
    localparam int DW  = 8;
    localparam int CPB = 16;
    localparam int LAT = 2 + CPB / 2 + (DW + 1) * CPB + 1;

    logic clk = 0, rst = 1, din = 1, ready = 1;
    logic [DW-1:0] dout;
    logic valid, frame_err, overrun;

    int cyc = 0, checks = 0, errors = 0, both = 0;
    logic valid_q = 0;
    bit m_held = 0;
    int obs_rise[$], obs_fall[$], obs_ferr[$], obs_ovr[$];
    logic [7:0] obs_dat[$];
    int exp_rise[$], exp_ferr[$], exp_ovr[$];
    logic [7:0] exp_dat[$];

    serial_frame_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .din(din), .dout(dout), .valid(valid),
        .ready(ready), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid && !valid_q) begin
            obs_rise.push_back(cyc);
            obs_dat.push_back(dout);
        end
        if (!valid && valid_q) obs_fall.push_back(cyc);
        if (frame_err) obs_ferr.push_back(cyc);
        if (overrun) obs_ovr.push_back(cyc);
        if (frame_err && overrun) both <= both + 1;
        valid_q <= valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear();
        obs_rise.delete(); obs_fall.delete(); obs_ferr.delete(); obs_ovr.delete(); obs_dat.delete();
        exp_rise.delete(); exp_ferr.delete(); exp_ovr.delete(); exp_dat.delete();
    endtask

    task automatic model_frame(input int t, input logic [7:0] b, input bit stop);
        if (!stop) exp_ferr.push_back(t + LAT);
        else if (m_held && !ready) exp_ovr.push_back(t + LAT);
        else begin
            exp_rise.push_back(t + LAT);
            exp_dat.push_back(b);
            m_held = !ready;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        model_frame(cyc, b, stop);
        din = 0;
        tick(CPB);
        for (int i = 0; i < DW; i++) begin
            din = b[i];
            tick(CPB);
        end
        din = stop;
        tick(CPB);
        din = 1;
    endtask

    task automatic test_reset();
        #2 rst = 0;
        #1;
        checks += 4;
        if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", overrun); end
        tick(3);
        rst = 1;
        tick(5);
    endtask

    task automatic test_single();
        clear();
        ready = 1;
        send_frame(8'hA5, 1);
        tick(4);
        checks++;
        if (obs_rise.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", obs_rise.size()); end
        else begin
            checks += 3;
            if (obs_rise[0] != exp_rise[0]) begin errors++; $display("FAIL single_cycle got %0d want %0d", obs_rise[0], exp_rise[0]); end
            if (obs_dat[0] !== exp_dat[0]) begin errors++; $display("FAIL single_data got %h want %h", obs_dat[0], exp_dat[0]); end
            if (obs_fall.size() != 1 || obs_fall[0] != exp_rise[0] + 1) begin
                errors++; $display("FAIL single_valid_len falls %0d want one at %0d", obs_fall.size(), exp_rise[0] + 1);
            end
        end
    endtask

    task automatic test_glitch();
        clear();
        din = 0;
        tick(4);
        din = 1;
        tick(30);
        checks += 3;
        if (obs_rise.size() != 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", obs_rise.size()); end
        if (obs_ferr.size() != 0) begin errors++; $display("FAIL glitch_ferr got %0d want 0", obs_ferr.size()); end
        if (valid !== 1'b0) begin errors++; $display("FAIL glitch_valid_lvl got %b want 0", valid); end
        send_frame(8'h3C, 1);
        tick(4);
        checks++;
        if (obs_rise.size() != 1) begin errors++; $display("FAIL glitch_next_count got %0d want 1", obs_rise.size()); end
        else begin
            checks += 2;
            if (obs_dat[0] !== 8'h3C) begin errors++; $display("FAIL glitch_next_data got %h want 3c", obs_dat[0]); end
            if (obs_rise[0] != exp_rise[0]) begin errors++; $display("FAIL glitch_next_cycle got %0d want %0d", obs_rise[0], exp_rise[0]); end
        end
    endtask

    task automatic test_frame_err();
        clear();
        send_frame(8'h3C, 0);
        tick(16);
        checks += 3;
        if (obs_ferr.size() != 1 || obs_ferr[0] != exp_ferr[0]) begin
            errors++; $display("FAIL ferr_pulse count %0d want one at %0d", obs_ferr.size(), exp_ferr[0]);
        end
        if (obs_rise.size() != 0) begin errors++; $display("FAIL ferr_valid got %0d rises want 0", obs_rise.size()); end
        if (obs_ovr.size() != 0) begin errors++; $display("FAIL ferr_ovr got %0d want 0", obs_ovr.size()); end
        send_frame(8'h01, 1);
        tick(4);
        checks++;
        if (obs_rise.size() != 1 || obs_dat[0] !== 8'h01) begin
            errors++; $display("FAIL ferr_recover rises %0d data %h want 1 rise of 01", obs_rise.size(), obs_dat[0]);
        end
    endtask

    task automatic test_overrun();
        clear();
        ready = 0;
        send_frame(8'h11, 1);
        send_frame(8'h22, 1);
        tick(4);
        checks += 5;
        if (obs_rise.size() != 1 || obs_dat[0] !== 8'h11) begin
            errors++; $display("FAIL ovr_first rises %0d data %h want 1 rise of 11", obs_rise.size(), obs_dat[0]);
        end
        if (obs_ovr.size() != 1 || obs_ovr[0] != exp_ovr[0]) begin
            errors++; $display("FAIL ovr_pulse count %0d want one at %0d", obs_ovr.size(), exp_ovr[0]);
        end
        if (dout !== 8'h11) begin errors++; $display("FAIL ovr_hold got %h want 11", dout); end
        if (valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", valid); end
        if (obs_ferr.size() != 0) begin errors++; $display("FAIL ovr_ferr got %0d want 0", obs_ferr.size()); end
        ready = 1;
        m_held = 0;
        tick(1);
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL ovr_consume got %b want 0", valid); end
    endtask

    task automatic test_reset_mid();
        clear();
        din = 0;
        tick(CPB);
        din = 1;
        tick(3 * CPB + CPB / 2);
        rst = 0;
        #1;
        checks += 4;
        if (dout !== 8'h00) begin errors++; $display("FAIL midrst_dout got %h want 00", dout); end
        if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", valid); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_ferr got %b want 0", frame_err); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_ovr got %b want 0", overrun); end
        tick(2);
        rst = 1;
        m_held = 0;
        tick(CPB);
        send_frame(8'h5A, 1);
        tick(4);
        checks += 2;
        if (obs_rise.size() != 1 || obs_dat[0] !== 8'h5A) begin
            errors++; $display("FAIL midrst_next rises %0d data %h want 1 rise of 5a", obs_rise.size(), obs_dat[0]);
        end
        if (obs_ferr.size() != 0) begin errors++; $display("FAIL midrst_ferr_after got %0d want 0", obs_ferr.size()); end
    endtask

    task automatic test_back_to_back();
        clear();
        send_frame(8'h00, 1);
        send_frame(8'hFF, 1);
        tick(4);
        checks++;
        if (obs_rise.size() != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", obs_rise.size()); end
        else begin
            checks += 3;
            if (obs_rise[1] - obs_rise[0] != 10 * CPB) begin
                errors++; $display("FAIL b2b_spacing got %0d want %0d", obs_rise[1] - obs_rise[0], 10 * CPB);
            end
            if (obs_dat[0] !== 8'h00) begin errors++; $display("FAIL b2b_first got %h want 00", obs_dat[0]); end
            if (obs_dat[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h want ff", obs_dat[1]); end
        end
    endtask

    task automatic test_random();
        clear();
        for (int k = 0; k < 12; k++) begin
            logic [7:0] b;
            bit stop;
            ready = $urandom_range(0, 3) != 0;
            if (ready) m_held = 0;
            b = 8'($urandom);
            stop = $urandom_range(0, 4) != 0;
            send_frame(b, stop);
            tick($urandom_range(3, 25));
        end
        ready = 1;
        m_held = 0;
        tick(4);
        checks += 4;
        if (obs_rise.size() != exp_rise.size()) begin errors++; $display("FAIL rand_rises got %0d want %0d", obs_rise.size(), exp_rise.size()); end
        if (obs_ferr.size() != exp_ferr.size()) begin errors++; $display("FAIL rand_ferrs got %0d want %0d", obs_ferr.size(), exp_ferr.size()); end
        if (obs_ovr.size() != exp_ovr.size()) begin errors++; $display("FAIL rand_ovrs got %0d want %0d", obs_ovr.size(), exp_ovr.size()); end
        if (both != 0) begin errors++; $display("FAIL rand_flags_together got %0d want 0", both); end
        for (int i = 0; i < exp_rise.size() && i < obs_rise.size(); i++) begin
            checks += 2;
            if (obs_rise[i] != exp_rise[i]) begin errors++; $display("FAIL rand_rise_cycle[%0d] got %0d want %0d", i, obs_rise[i], exp_rise[i]); end
            if (obs_dat[i] !== exp_dat[i]) begin errors++; $display("FAIL rand_data[%0d] got %h want %h", i, obs_dat[i], exp_dat[i]); end
        end
        for (int i = 0; i < exp_ferr.size() && i < obs_ferr.size(); i++) begin
            checks++;
            if (obs_ferr[i] != exp_ferr[i]) begin errors++; $display("FAIL rand_ferr_cycle[%0d] got %0d want %0d", i, obs_ferr[i], exp_ferr[i]); end
        end
        for (int i = 0; i < exp_ovr.size() && i < obs_ovr.size(); i++) begin
            checks++;
            if (obs_ovr[i] != exp_ovr[i]) begin errors++; $display("FAIL rand_ovr_cycle[%0d] got %0d want %0d", i, obs_ovr[i], exp_ovr[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
